// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator for N pixels per clock. Produces sync, data
//   enable, coordinates and frame/line start strobes, with a graceful stop
//   that always finishes the frame in flight.
//
//   Optional feature macro: VTG_TEST_PATTERN_EN
//     defined   -> adds pix_data, a diagonal-ramp test pattern per lane
//     undefined -> pix_data port and pattern logic are absent
//
// Ports
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   run request, sampled every cycle
//   HSYNC      out  horizontal sync, active level HS_POL
//   VSYNC      out  vertical sync, active level VS_POL (line aligned)
//   DE         out  active-video enable
//   FS         out  pulse on the first active beat of a frame
//   LS         out  pulse on the first active beat of each active line
//   x          out  pixel coordinate of lane 0 (steps by PPC), 0 outside DE
//   y          out  active line index, 0 outside active lines
//   frame_cnt  out  completed-frame count, wraps
//   busy       out  high while running or finishing a frame
//   pix_data   out  (VTG_TEST_PATTERN_EN only) PPC lanes of DW bits
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 2448,
  parameter int H_FP     = 40,
  parameter int H_SW     = 40,
  parameter int H_BP     = 72,
  parameter int V_ACTIVE = 2048,
  parameter int V_FP     = 4,
  parameter int V_SW     = 4,
  parameter int V_BP     = 16,
  parameter int PPC      = 1,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int DW       = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  output logic                        HSYNC,
  output logic                        VSYNC,
  output logic                        DE,
  output logic                        FS,
  output logic                        LS,
  output logic [$clog2(H_ACTIVE)-1:0] x,
  output logic [$clog2(V_ACTIVE)-1:0] y,
  output logic [15:0]                 frame_cnt,
  output logic                        busy
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [PPC*DW-1:0]           pix_data
`endif
);

  // Horizontal timing is counted in beats (clock cycles), vertical in lines.
  localparam int XW   = $clog2(H_ACTIVE);
  localparam int YW   = $clog2(V_ACTIVE);
  localparam int HA_B = H_ACTIVE / PPC;
  localparam int HF_B = H_FP / PPC;
  localparam int HS_B = H_SW / PPC;
  localparam int HB_B = H_BP / PPC;
  localparam int HT_B = HA_B + HF_B + HS_B + HB_B;
  localparam int VT   = V_ACTIVE + V_FP + V_SW + V_BP;

  // One extra bit of headroom so every boundary (including the totals) fits.
  localparam int HCW = $clog2(HT_B + 1);
  localparam int VCW = $clog2(VT + 1);

  localparam logic [HCW-1:0] H_LAST   = HCW'(HT_B - 1);
  localparam logic [HCW-1:0] HA_END   = HCW'(HA_B);
  localparam logic [HCW-1:0] HS_BEG   = HCW'(HA_B + HF_B);
  localparam logic [HCW-1:0] HS_END   = HCW'(HA_B + HF_B + HS_B);
  localparam logic [VCW-1:0] V_LAST   = VCW'(VT - 1);
  localparam logic [VCW-1:0] VA_END   = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_BEG   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SW);

  // Elaboration-time parameter sanity checks.
  if (PPC != 1 && PPC != 2 && PPC != 4) begin : g_bad_ppc
    $error("video_timing_gen: PPC must be 1, 2 or 4");
  end
  if ((H_ACTIVE % PPC) != 0 || (H_FP % PPC) != 0 ||
      (H_SW % PPC) != 0 || (H_BP % PPC) != 0) begin : g_bad_div
    $error("video_timing_gen: horizontal timings must be divisible by PPC");
  end
  if (H_SW < 1 || V_SW < 1) begin : g_bad_sw
    $error("video_timing_gen: sync widths must be at least 1");
  end
  if (DW < 1) begin : g_bad_dw
    $error("video_timing_gen: DW must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [HCW-1:0] hcnt, h_n;
  logic [VCW-1:0] vcnt, v_n;
  logic           last_beat;
  logic           wrap;
  logic           act_n;
  logic           de_n;
  logic [XW-1:0]  x_n;
  logic [YW-1:0]  y_n;
  logic [15:0]    fc_n;

  // Next-beat computation. The registers below load the *next* counter
  // values together with outputs decoded from those same values, so every
  // output lines up with the counter state of its cycle without extra delay.
  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    h_n       = '0;
    v_n       = '0;
    wrap      = 1'b0;
    last_beat = (hcnt == H_LAST) && (vcnt == V_LAST);
    unique case (state)
      S_IDLE: begin
        // Counters stay at 0, which is exactly the first beat shown on entry.
        if (enable) state_n = S_RUN;
      end
      S_RUN, S_STOPPING: begin
        if (last_beat) begin
          wrap    = 1'b1;
          // A stop request only takes effect at the frame boundary.
          state_n = enable ? S_RUN : S_IDLE;
        end else begin
          state_n = enable ? S_RUN : S_STOPPING;
          if (hcnt == H_LAST) begin
            h_n = '0;
            v_n = vcnt + VCW'(1);
          end else begin
            h_n = hcnt + HCW'(1);
            v_n = vcnt;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    act_n = (state_n != S_IDLE);
    de_n  = act_n && (h_n < HA_END) && (v_n < VA_END);
    x_n   = de_n ? XW'(32'(h_n) * PPC) : '0;
    y_n   = (act_n && (v_n < VA_END)) ? YW'(v_n) : '0;
    fc_n  = frame_cnt + 16'(wrap);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      HSYNC     <= ~HS_POL;
      VSYNC     <= ~VS_POL;
      DE        <= 1'b0;
      FS        <= 1'b0;
      LS        <= 1'b0;
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      hcnt      <= h_n;
      vcnt      <= v_n;
      HSYNC     <= (act_n && (h_n >= HS_BEG) && (h_n < HS_END)) ? HS_POL : ~HS_POL;
      VSYNC     <= (act_n && (v_n >= VS_BEG) && (v_n < VS_END)) ? VS_POL : ~VS_POL;
      DE        <= de_n;
      FS        <= de_n && (h_n == '0) && (v_n == '0);
      LS        <= de_n && (h_n == '0);
      x         <= x_n;
      y         <= y_n;
      frame_cnt <= fc_n;
      busy      <= act_n;
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  // Lane k carries (x + k + y + frame_cnt) modulo 2^DW; the ramp shifts by
  // one every frame so a frozen source is visible on a monitor.
  logic [PPC*DW-1:0] pix_n;
  logic [DW-1:0]     pix_base;

  always_comb begin
    pix_n    = '0;
    pix_base = DW'(x_n) + DW'(y_n) + DW'(fc_n);
    if (de_n) begin
      for (int k = 0; k < PPC; k++) begin
        pix_n[k*DW +: DW] = pix_base + DW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_data <= '0;
    else        pix_data <= pix_n;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Two generators share clock, reset and enable: one at 1 pixel/clock with
//   positive sync polarity, one at 2 pixels/clock with negative polarity.
//   A frame-level reference model (beat index within the frame) predicts the
//   outputs after every clock edge; the predictions go into a scoreboard
//   queue that a separate monitor drains and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HSW = 2;
  localparam int HBP = 4;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSW = 1;
  localparam int VBP = 2;
  localparam int DW  = 12;
  localparam int HTOT = HA + HFP + HSW + HBP;
  localparam int VTOT = VA + VFP + VSW + VBP;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;

  logic       hs0, vs0, de0, fs0, ls0, busy0;
  logic [2:0] x0;
  logic [1:0] y0;
  logic [15:0] fc0;
  logic       hs1, vs1, de1, fs1, ls1, busy1;
  logic [2:0] x1;
  logic [1:0] y1;
  logic [15:0] fc1;
`ifdef VTG_TEST_PATTERN_EN
  logic [DW-1:0]   pix0;
  logic [2*DW-1:0] pix1;
`endif

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SW(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SW(VSW), .V_BP(VBP),
    .PPC(1), .HS_POL(1'b1), .VS_POL(1'b1), .DW(DW)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .HSYNC(hs0), .VSYNC(vs0), .DE(de0), .FS(fs0), .LS(ls0),
    .x(x0), .y(y0), .frame_cnt(fc0), .busy(busy0)
`ifdef VTG_TEST_PATTERN_EN
    , .pix_data(pix0)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SW(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SW(VSW), .V_BP(VBP),
    .PPC(2), .HS_POL(1'b0), .VS_POL(1'b0), .DW(DW)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .HSYNC(hs1), .VSYNC(vs1), .DE(de1), .FS(fs1), .LS(ls1),
    .x(x1), .y(y1), .frame_cnt(fc1), .busy(busy1)
`ifdef VTG_TEST_PATTERN_EN
    , .pix_data(pix1)
`endif
  );

  typedef struct packed {
    logic        hs, vs, de, fs, ls, busy;
    logic [2:0]  x;
    logic [1:0]  y;
    logic [15:0] fc;
    logic [23:0] pix;
  } vout_t;

  typedef struct packed {
    vout_t d1;
    vout_t d0;
  } pair_t;

  pair_t sb_q[$];
  int    fs_cyc[$];
  int    cycle  = 0;
  int    n_chk  = 0;
  int    n_pass = 0;

  // Reference model: per generator a running flag, the beat index within
  // the frame and the completed-frame count.
  int ppc_of [2] = '{1, 2};
  bit pol_of [2] = '{1'b1, 1'b0};
  bit m_run  [2];
  int m_beat [2];
  int m_fcnt [2];

  function automatic int line_beats(int id);
    return HTOT / ppc_of[id];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]  = 1'b0;
      m_beat[i] = 0;
      m_fcnt[i] = 0;
    end
  endtask

  task automatic model_step(int id, logic en);
    if (!m_run[id]) begin
      if (en) begin
        m_run[id]  = 1'b1;
        m_beat[id] = 0;
      end
    end else if (m_beat[id] == line_beats(id) * VTOT - 1) begin
      m_fcnt[id] = m_fcnt[id] + 1;
      m_beat[id] = 0;
      if (!en) m_run[id] = 1'b0;
    end else begin
      m_beat[id] = m_beat[id] + 1;
    end
  endtask

  function automatic vout_t reset_vec(int id);
    vout_t o = '0;
    o.hs = ~pol_of[id];
    o.vs = ~pol_of[id];
    return o;
  endfunction

  function automatic vout_t expect_out(int id);
    vout_t o = '0;
    bit in_hs = 1'b0;
    bit in_vs = 1'b0;
    int p, ln;
    o.fc   = 16'(m_fcnt[id]);
    o.busy = m_run[id];
    if (m_run[id]) begin
      p     = (m_beat[id] % line_beats(id)) * ppc_of[id];
      ln    = m_beat[id] / line_beats(id);
      in_hs = (p >= HA + HFP) && (p < HA + HFP + HSW);
      in_vs = (ln >= VA + VFP) && (ln < VA + VFP + VSW);
      o.de  = (p < HA) && (ln < VA);
      o.x   = o.de ? 3'(p) : 3'd0;
      o.y   = (ln < VA) ? 2'(ln) : 2'd0;
      o.fs  = o.de && (m_beat[id] == 0);
      o.ls  = o.de && (p == 0);
`ifdef VTG_TEST_PATTERN_EN
      if (o.de) begin
        for (int k = 0; k < ppc_of[id]; k++) begin
          o.pix[k*DW +: DW] = DW'(p + k + ln + m_fcnt[id]);
        end
      end
`endif
    end
    o.hs = in_hs ? pol_of[id] : ~pol_of[id];
    o.vs = in_vs ? pol_of[id] : ~pol_of[id];
    return o;
  endfunction

  function automatic vout_t actual(int id);
    vout_t o = '0;
    if (id == 0) begin
      o.hs = hs0; o.vs = vs0; o.de = de0; o.fs = fs0; o.ls = ls0;
      o.busy = busy0; o.x = x0; o.y = y0; o.fc = fc0;
`ifdef VTG_TEST_PATTERN_EN
      o.pix = 24'(pix0);
`endif
    end else begin
      o.hs = hs1; o.vs = vs1; o.de = de1; o.fs = fs1; o.ls = ls1;
      o.busy = busy1; o.x = x1; o.y = y1; o.fc = fc1;
`ifdef VTG_TEST_PATTERN_EN
      o.pix = pix1;
`endif
    end
    return o;
  endfunction

  task automatic check(string name, vout_t act, vout_t exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cycle %0d: actual hs=%b vs=%b de=%b fs=%b ls=%b busy=%b x=%0d y=%0d fc=%0d pix=%h | expected hs=%b vs=%b de=%b fs=%b ls=%b busy=%b x=%0d y=%0d fc=%0d pix=%h",
               name, cycle, act.hs, act.vs, act.de, act.fs, act.ls, act.busy, act.x, act.y, act.fc, act.pix,
               exp.hs, exp.vs, exp.de, exp.fs, exp.ls, exp.busy, exp.x, exp.y, exp.fc, exp.pix);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d expected %0d", name, act, exp);
  endtask

  // One clock of stimulus: present enable, let the edge happen, then push
  // the model's prediction for the outputs that edge produced.
  task automatic cyc(logic en);
    pair_t e;
    enable = en;
    @(posedge clk);
    cycle++;
    model_step(0, en);
    model_step(1, en);
    e.d0 = expect_out(0);
    e.d1 = expect_out(1);
    sb_q.push_back(e);
    #2;
  endtask

  // Monitor: compares whenever a prediction is pending, half a cycle after
  // the edge that produced it.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("raster_ppc1", actual(0), e.d0);
        check("raster_ppc2", actual(1), e.d1);
        if (fs0 === 1'b1) fs_cyc.push_back(cycle);
      end
    end
  end

  initial begin
    logic en;
    int   n;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_ppc1", actual(0), reset_vec(0));
    check("reset_ppc2", actual(1), reset_vec(1));
    rst_n = 1'b1;
    repeat (5) cyc(1'b0);

    // Basic raster, then enable dropped at frame 1 beat 20: frame 1 completes.
    fs_cyc.delete();
    repeat (148) cyc(1'b1);
    repeat (160) cyc(1'b0);
    @(negedge clk); #1;
    check_int("stop_frame_cnt_ppc1", int'(fc0), 2);
    check_int("stop_busy_ppc1", int'(busy0), 0);
    check_int("stop_frame_cnt_ppc2", int'(fc1), 3);
    check_int("stop_fs_count", fs_cyc.size(), 2);
    if (fs_cyc.size() >= 2) check_int("fs_period", fs_cyc[1] - fs_cyc[0], 128);

    // Re-enable while finishing the frame: no gap between frames.
    fs_cyc.delete();
    repeat (148) cyc(1'b1);
    repeat (40)  cyc(1'b0);
    repeat (200) cyc(1'b1);
    @(negedge clk); #1;
    check_int("reenable_fs_count", fs_cyc.size(), 4);
    if (fs_cyc.size() >= 3) check_int("reenable_fs_gap", fs_cyc[2] - fs_cyc[1], 128);
    repeat (260) cyc(1'b0);

    // Asynchronous reset in the middle of an active line (frame 0, beat 35).
    repeat (36) cyc(1'b1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_reset_ppc1", actual(0), reset_vec(0));
    check("async_reset_ppc2", actual(1), reset_vec(1));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    fs_cyc.delete();
    n = cycle;
    repeat (3) cyc(1'b1);
    @(negedge clk); #1;
    check_int("restart_fs_count", fs_cyc.size(), 1);
    if (fs_cyc.size() >= 1) check_int("restart_fs_cycle", fs_cyc[0], n + 1);

    // Randomised enable segments, mostly running.
    repeat (25) begin
      en = ($urandom_range(0, 3) != 0);
      n  = $urandom_range(1, 250);
      repeat (n) cyc(en);
    end
    repeat (300) cyc(1'b0);

    @(negedge clk); #1;
    check_int("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
